// File: rtl/pack_sched_pkg.sv
// Shared types and helpers for the round-robin bit-packing scheduler.
package pack_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Index width that stays legal even for a single requester
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pack_rr_sched_rr_pick.sv
// Combinational round-robin selector: first asserted request after last.
module rr_pick
    import pack_sched_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int ID_W = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    // Scan farthest-first so the nearest lane after last is kept
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (req[j] && (j == (int'(last) + k) % NREQ)) begin
                    any = 1'b1;
                    idx = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/pack_rr_sched.sv
// Round-robin scheduler packing WIDTH serial bits from one of NREQ
// requesters into a word presented on a valid/ready port.
module pack_rr_sched
    import pack_sched_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int WIDTH = 3,
    localparam int ID_W  = clog2_min1(NREQ),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_bit,
    output logic [NREQ-1:0]  req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [ID_W-1:0]  out_id,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  pick_idx;
    logic [CNT_W-1:0] cnt;
    logic [NREQ-1:0]  grant_oh;
    logic             pick_any;
    logic             accept;
    logic             in_bit;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req  (req_valid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = (grant == ID_W'(i));
        end
    end

    // req_ready is one-hot in PACK, so these only see the granted lane
    assign accept = |(req_valid & req_ready);
    assign in_bit = |(req_bit & req_ready);
    assign out_id = grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = pick_any ? PACK : IDLE;
            PACK:    state_nx = (accept && cnt == LAST) ? HOLD : PACK;
            HOLD:    state_nx = out_ready ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == PACK) ? grant_oh : '0;
        busy      = (state == PACK) || (state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= ID_W'(NREQ - 1);
            cnt        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant    <= pick_idx;
                        cnt      <= '0;
                        out_data <= '0;
                    end
                end
                PACK: begin
                    if (accept) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                out_data[i] <= in_bit;
                            end
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        last_grant <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pack_rr_sched.sv
// Self-checking bench for pack_rr_sched: directed scenarios on the default
// configuration plus randomized scoreboard runs on three parameter sets.
module tb_pack_rr_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0][7:0] rv, rb, rdy, od;
    logic [2:0][2:0] oid;
    logic [2:0]      ordy, ov, bsy;

    logic [2:0] rdy0, od0;
    logic [1:0] id0;
    logic       ov0, bsy0;
    logic [1:0] rdy1;
    logic [7:0] od1;
    logic [0:0] id1;
    logic       ov1, bsy1;
    logic [4:0] rdy2;
    logic [1:0] od2;
    logic [2:0] id2;
    logic       ov2, bsy2;

    int nvec = 0;
    int nerr = 0;

    pack_rr_sched #(.NREQ(3), .WIDTH(3)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv[0][2:0]), .req_bit(rb[0][2:0]), .req_ready(rdy0),
        .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0),
        .out_id(id0), .busy(bsy0)
    );

    pack_rr_sched #(.NREQ(2), .WIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(rv[1][1:0]), .req_bit(rb[1][1:0]), .req_ready(rdy1),
        .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1),
        .out_id(id1), .busy(bsy1)
    );

    pack_rr_sched #(.NREQ(5), .WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(rv[2][4:0]), .req_bit(rb[2][4:0]), .req_ready(rdy2),
        .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2),
        .out_id(id2), .busy(bsy2)
    );

    always_comb begin
        rdy = '0; od = '0; oid = '0; ov = '0; bsy = '0;
        rdy[0] = 8'(rdy0); od[0] = 8'(od0); oid[0] = 3'(id0);
        ov[0] = ov0; bsy[0] = bsy0;
        rdy[1] = 8'(rdy1); od[1] = od1; oid[1] = 3'(id1);
        ov[1] = ov1; bsy[1] = bsy1;
        rdy[2] = 8'(rdy2); od[2] = 8'(od2); oid[2] = id2;
        ov[2] = ov2; bsy[2] = bsy2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rv = '0; rb = '0; ordy = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Spec-level arbitration: first requesting lane after the previous winner
    function automatic int rr_next(input int last, input logic [7:0] v,
                                   input int n);
        for (int k = 1; k <= n; k++) begin
            if (v[(last + k) % n]) return (last + k) % n;
        end
        return -1;
    endfunction

    task automatic test_reset();
        nvec++;
        if ({ov[0], bsy[0], od[0], oid[0], rdy[0]} !== '0) begin
            nerr++;
            $display("FAIL reset_init: got ov=%b busy=%b data=%h id=%0d rdy=%b want all 0",
                     ov[0], bsy[0], od[0], oid[0], rdy[0]);
        end
        rst = 1'b0;
        rv[0] = 8'b010; rb[0] = 8'b010;
        tick();
        nvec++;
        if (rdy[0] !== 8'b010 || bsy[0] !== 1'b1) begin
            nerr++;
            $display("FAIL reset_grant1: got rdy=%b busy=%b want 010 1", rdy[0], bsy[0]);
        end
        tick();
        tick();
        nvec++;
        if (od[0] !== 8'b011 || oid[0] !== 3'd1) begin
            nerr++;
            $display("FAIL reset_partial: got data=%b id=%0d want 011 1", od[0], oid[0]);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({ov[0], bsy[0], od[0], oid[0], rdy[0]} !== '0) begin
            nerr++;
            $display("FAIL reset_async: got ov=%b busy=%b data=%h id=%0d rdy=%b want all 0",
                     ov[0], bsy[0], od[0], oid[0], rdy[0]);
        end
        tick();
        rst = 1'b0;
        rv[0] = 8'b011; rb[0] = 8'b001;
        tick();
        nvec++;
        if (rdy[0] !== 8'b001 || ov[0] !== 1'b0) begin
            nerr++;
            $display("FAIL reset_lane0_first: got rdy=%b ov=%b want 001 0", rdy[0], ov[0]);
        end
        repeat (3) tick();
        nvec++;
        if (ov[0] !== 1'b1 || od[0] !== 8'b111 || oid[0] !== 3'd0) begin
            nerr++;
            $display("FAIL reset_word: got ov=%b data=%b id=%0d want 1 111 0",
                     ov[0], od[0], oid[0]);
        end
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        rv[0] = '0;
    endtask

    task automatic test_pack_order();
        int s[6] = '{1, 0, 1, 0, 1, 1};
        logic [7:0] expw[2] = '{8'b101, 8'b110};
        rv[0] = 8'b010;
        for (int w = 0; w < 2; w++) begin
            tick();
            for (int j = 0; j < 3; j++) begin
                nvec++;
                if (ov[0] !== 1'b0) begin
                    nerr++;
                    $display("FAIL order_early_valid w%0d b%0d: got %b want 0", w, j, ov[0]);
                end
                rb[0] = (s[w * 3 + j] != 0) ? 8'b010 : 8'b000;
                tick();
            end
            nvec++;
            if (ov[0] !== 1'b1 || od[0] !== expw[w] || oid[0] !== 3'd1) begin
                nerr++;
                $display("FAIL order_word%0d: got ov=%b data=%b id=%0d want 1 %b 1",
                         w, ov[0], od[0], oid[0], expw[w]);
            end
            ordy[0] = 1'b1;
            tick();
            ordy[0] = 1'b0;
        end
        rv[0] = '0;
    endtask

    task automatic test_round_robin();
        logic [7:0] ew, eoh;
        int id;
        do_reset();
        rv[0] = 8'b111;
        for (int w = 0; w < 6; w++) begin
            id = w % 3;
            ew = '0;
            eoh = '0;
            eoh[id] = 1'b1;
            tick();
            for (int j = 0; j < 3; j++) begin
                rb[0] = 8'($urandom_range(0, 7));
                ew[j] = rb[0][id];
                nvec++;
                if (rdy[0] !== eoh) begin
                    nerr++;
                    $display("FAIL rr_ready w%0d b%0d: got %b want %b", w, j, rdy[0], eoh);
                end
                tick();
            end
            nvec++;
            if (ov[0] !== 1'b1 || od[0] !== ew || oid[0] !== 3'(id)) begin
                nerr++;
                $display("FAIL rr_word%0d: got ov=%b data=%b id=%0d want 1 %b %0d",
                         w, ov[0], od[0], oid[0], ew, id);
            end
            ordy[0] = 1'b1;
            tick();
            ordy[0] = 1'b0;
        end
        rv[0] = '0;
    endtask

    task automatic test_stall_in();
        rv[0] = 8'b100;
        tick();
        nvec++;
        if (rdy[0] !== 8'b100) begin
            nerr++;
            $display("FAIL stall_grant: got %b want 100", rdy[0]);
        end
        rb[0] = 8'b000;
        tick();
        rb[0] = 8'b100;
        tick();
        rv[0] = 8'b011;
        for (int c = 0; c < 4; c++) begin
            rb[0] = 8'($urandom_range(0, 7));
            tick();
            nvec++;
            if (rdy[0] !== 8'b100 || ov[0] !== 1'b0) begin
                nerr++;
                $display("FAIL stall_hold c%0d: got rdy=%b ov=%b want 100 0", c, rdy[0], ov[0]);
            end
        end
        rv[0] = 8'b100;
        rb[0] = 8'b100;
        tick();
        nvec++;
        if (ov[0] !== 1'b1 || od[0] !== 8'b110 || oid[0] !== 3'd2 || rdy[0] !== 8'b0) begin
            nerr++;
            $display("FAIL stall_word: got ov=%b data=%b id=%0d rdy=%b want 1 110 2 000",
                     ov[0], od[0], oid[0], rdy[0]);
        end
        rv[0] = '0;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
    endtask

    task automatic test_backpressure();
        int s[3] = '{1, 1, 0};
        rv[0] = 8'b001;
        tick();
        for (int j = 0; j < 3; j++) begin
            rb[0] = (s[j] != 0) ? 8'b001 : 8'b000;
            tick();
        end
        rv[0] = 8'b111;
        for (int c = 0; c < 5; c++) begin
            rb[0] = 8'($urandom_range(0, 7));
            tick();
            nvec++;
            if (ov[0] !== 1'b1 || od[0] !== 8'b011 || oid[0] !== 3'd0 ||
                rdy[0] !== 8'b0 || bsy[0] !== 1'b1) begin
                nerr++;
                $display("FAIL bp_hold c%0d: got ov=%b data=%b id=%0d rdy=%b busy=%b want 1 011 0 000 1",
                         c, ov[0], od[0], oid[0], rdy[0], bsy[0]);
            end
        end
        ordy[0] = 1'b1;
        tick();
        nvec++;
        if (ov[0] !== 1'b0 || bsy[0] !== 1'b0 || rdy[0] !== 8'b0) begin
            nerr++;
            $display("FAIL bp_release: got ov=%b busy=%b rdy=%b want 0 0 000", ov[0], bsy[0], rdy[0]);
        end
        rv[0] = '0;
        tick();
        nvec++;
        if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            nerr++;
            $display("FAIL bp_idle_ready: got ov=%b busy=%b want 0 0", ov[0], bsy[0]);
        end
        ordy[0] = 1'b0;
    endtask

    // Scoreboard run: words are rebuilt from the bits the model says were taken
    task automatic test_random(input int k, input int n, input int w, input int cycles);
        int phase, cur, last, cnt_m, id;
        int waits[8];
        logic [7:0] word, er, vn, bn, gvalid;
        logic r;
        do_reset();
        phase = 0; cur = 0; last = n - 1; cnt_m = 0;
        word = '0; gvalid = '0;
        for (int i = 0; i < 8; i++) waits[i] = 0;
        for (int c = 0; c < cycles; c++) begin
            er = '0;
            if (phase == 1) er[cur] = 1'b1;
            nvec++;
            if (rdy[k] !== er) begin
                nerr++;
                $display("FAIL rand%0d_ready c%0d: got %b want %b", k, c, rdy[k], er);
            end
            nvec++;
            if (ov[k] !== (phase == 2)) begin
                nerr++;
                $display("FAIL rand%0d_valid c%0d: got %b want %b", k, c, ov[k], phase == 2);
            end
            vn = '0; bn = '0;
            for (int i = 0; i < n; i++) begin
                vn[i] = ($urandom_range(0, 4) != 0);
                bn[i] = 1'($urandom);
            end
            r = ($urandom_range(0, 2) != 0);
            rv[k] = vn; rb[k] = bn; ordy[k] = r;
            if (phase == 0) begin
                if (vn != 0) begin
                    cur = rr_next(last, vn, n);
                    gvalid = vn;
                    word = '0; cnt_m = 0; phase = 1;
                end
            end else if (phase == 1) begin
                if (vn[cur]) begin
                    word[cnt_m] = bn[cur];
                    cnt_m++;
                    if (cnt_m == w) phase = 2;
                end
            end else if (r) begin
                nvec++;
                if (od[k] !== word || oid[k] !== 3'(cur)) begin
                    nerr++;
                    $display("FAIL rand%0d_word c%0d: got data=%h id=%0d want %h %0d",
                             k, c, od[k], oid[k], word, cur);
                end
                id = int'(oid[k]);
                for (int i = 0; i < n; i++) begin
                    if (i == id || !gvalid[i]) waits[i] = 0;
                    else waits[i]++;
                    nvec++;
                    if (waits[i] > n - 1) begin
                        nerr++;
                        $display("FAIL rand%0d_fair lane%0d: got wait %0d want <= %0d",
                                 k, i, waits[i], n - 1);
                    end
                end
                last = cur;
                phase = 0;
            end
            tick();
        end
        rv[k] = '0; ordy[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rv = '0; rb = '0; ordy = '0;
        tick();
        tick();
        test_reset();
        test_pack_order();
        test_round_robin();
        test_stall_in();
        test_backpressure();
        test_random(0, 3, 3, 600);
        test_random(1, 2, 8, 800);
        test_random(2, 5, 2, 800);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
